// File: rtl/serial_adder_n.sv
// Bit-serial WIDTH-bit adder/subtractor: one operand bit per clock, LSB first,
// with a one-cycle Done pulse and registered Sum/Cout/Ovf.
module serial_adder_n #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             Start,
    input  logic             Sub,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             Busy,
    output logic             Done,
    output logic [WIDTH-1:0] Sum,
    output logic             Cout,
    output logic             Ovf
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             carry_q, carry_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic             bit_s;
    logic             bit_c;
    logic [WIDTH-1:0] res_next;

    always_comb begin
        bit_s    = a_q[0] ^ b_q[0] ^ carry_q;
        bit_c    = (a_q[0] & b_q[0]) | (a_q[0] & carry_q) | (b_q[0] & carry_q);
        res_next = (res_q >> 1) | (WIDTH'(bit_s) << (WIDTH - 1));

        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        res_d   = res_q;
        sum_d   = sum_q;
        cnt_d   = cnt_q;
        carry_d = carry_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;

        case (state_q)
            IDLE: begin
                if (Start) begin
                    a_d     = A;
                    b_d     = Sub ? ~B : B;
                    carry_d = Sub;
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                a_d     = a_q >> 1;
                b_d     = b_q >> 1;
                carry_d = bit_c;
                res_d   = res_next;
                cnt_d   = cnt_q + CW'(1);
                // The carry entering the MSB is the one still held in carry_q here.
                if (cnt_q == CW'(WIDTH - 1)) begin
                    sum_d   = res_next;
                    cout_d  = bit_c;
                    ovf_d   = carry_q ^ bit_c;
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
        done_d = (state_d == DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            sum_q   <= '0;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
            sum_q   <= sum_d;
            cnt_q   <= cnt_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign Busy = busy_q;
    assign Done = done_q;
    assign Sum  = sum_q;
    assign Cout = cout_q;
    assign Ovf  = ovf_q;

endmodule

// File: doc/serial_adder_n.md
SERIAL_ADDER_N -- requirements
Module: serial_adder_n

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, meaning operand and result width in bits; legal range is 1 to 64.
REQ-002 Port clk SHALL be input, 1 bit: single rising-edge clock for all state.
REQ-003 Port rst_n SHALL be input, 1 bit: asynchronous, active-low reset.
REQ-004 Port Start SHALL be input, 1 bit: operation request, sampled on clk rising edge.
REQ-005 Port Sub SHALL be input, 1 bit: mode select, 0 = A+B, 1 = A-B; sampled with Start.
REQ-006 Port A SHALL be input, WIDTH bits: first operand.
REQ-007 Port B SHALL be input, WIDTH bits: second operand.
REQ-008 Port Busy SHALL be output, 1 bit: high when the block is not in IDLE.
REQ-009 Port Done SHALL be output, 1 bit: single-cycle completion pulse.
REQ-010 Port Sum SHALL be output, WIDTH bits: registered result.
REQ-011 Port Cout SHALL be output, 1 bit: final carry; for subtract, 1 means no borrow.
REQ-012 Port Ovf SHALL be output, 1 bit: two's-complement signed overflow.

Function
REQ-013 The FSM SHALL have states IDLE, RUN and DONE, and SHALL use a bit counter sized to hold 0..WIDTH.
REQ-014 In IDLE with Start=1 on edge k, the block SHALL perform all of the following, then enter RUN:
- capture A;
- capture B, inverted when Sub=1;
- set carry to Sub;
- clear the counter.
REQ-015 In IDLE with Start=0, the block SHALL remain in IDLE with all outputs holding their values.
REQ-016 In RUN, each edge SHALL process one bit, LSB first:
- s = a(i) xor b(i) xor c;
- c' = majority(a(i), b(i), c);
- s is shifted into an internal result register at the MSB end;
- the counter increments.
REQ-017 RUN SHALL last exactly WIDTH edges (k+1 .. k+WIDTH), with no early termination for any operand value.
REQ-018 On edge k+WIDTH the block SHALL enter DONE and load the outputs as follows:
- Sum = internal result;
- Cout = final carry;
- Ovf = carry into MSB xor final carry.
REQ-019 Done SHALL be 1 only during the DONE cycle, which lasts exactly one cycle; on edge k+WIDTH+1 the block SHALL return to IDLE.
REQ-020 Busy SHALL be 1 in RUN and DONE, and 0 in IDLE.
REQ-021 Start SHALL be ignored in RUN and DONE; the earliest next acceptance is edge k+WIDTH+2.
REQ-022 Changes on A, B or Sub after edge k SHALL NOT affect the operation in progress.
REQ-023 Sum, Cout and Ovf SHALL NOT change during RUN; they SHALL hold the previous result until the next DONE load.
REQ-024 Arithmetic SHALL be modulo 2^WIDTH; Sub SHALL compute A + ~B + 1.
REQ-025 For WIDTH=1 the block SHALL behave as a registered full adder/subtractor with exactly one RUN cycle.
REQ-026 Start held continuously high SHALL produce one operation per IDLE visit, i.e. one result every WIDTH+2 cycles.

Reset
REQ-027 While rst_n=0, the block SHALL immediately, without waiting for clk, force the state to IDLE and drive Busy, Done, Sum, Cout and Ovf to 0.
REQ-028 Reset asserted during RUN or DONE SHALL abort the operation, discard the partial result, and produce no Done pulse.
REQ-029 After rst_n deasserts, the first rising edge with Start=1 SHALL be accepted normally.

Verification (WIDTH=8 unless stated)
REQ-030 The bench SHALL apply rst_n=0 mid-simulation with no clock edge and check that Busy, Done, Sum, Cout and Ovf are 0 at once.
REQ-031 The bench SHALL apply A=0x0F, B=0x01, Sub=0 with a one-cycle Start pulse and check:
- Busy high for 9 cycles;
- Done high exactly in cycle 9 after acceptance;
- Sum=0x10, Cout=0, Ovf=0.
REQ-032 The bench SHALL check add boundaries:
- A=0xFF, B=0x01 -> Sum=0x00, Cout=1, Ovf=0;
- A=0x7F, B=0x01 -> Sum=0x80, Cout=0, Ovf=1.
REQ-033 The bench SHALL check subtract:
- A=0x05, B=0x07 -> Sum=0xFE, Cout=0, Ovf=0;
- A=0x80, B=0x01 -> Sum=0x7F, Cout=1, Ovf=1.
REQ-034 The bench SHALL hold Start=1 and change A/B during RUN, then check:
- the result uses the captured operands;
- the next acceptance occurs exactly WIDTH+2 cycles later.
REQ-035 The bench SHALL pulse rst_n low on the 4th RUN cycle and check:
- outputs go to 0 immediately;
- no Done pulse;
- a following Start with A=0x03, B=0x04 yields Sum=0x07.
REQ-036 The bench SHALL run all 8 input combinations of A, B and Sub at WIDTH=1 and match the half/full-adder truth table for Sum and Cout.
